// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory port arbiter.
//            Contains the FSM state encoding, the owner encoding, the whb
//            access-size codes and a width helper for the starvation counter.
// Ports    : none (package)
// Config   : MEM_ARB_FAIR_EN selects the fairness counter in the users of
//            this package; the package itself is unconditional.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Access size/sign codes, identical to the decoder's whb field.
    localparam logic [2:0] WHB_B  = 3'd0;
    localparam logic [2:0] WHB_H  = 3'd1;
    localparam logic [2:0] WHB_W  = 3'd2;
    localparam logic [2:0] WHB_BU = 3'd3;
    localparam logic [2:0] WHB_HU = 3'd4;

    // Bits needed to hold the values 0..limit (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_fair_ctr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_fair_ctr
// Purpose  : Saturating starvation counter. Counts data grants made while a
//            fetch request is waiting; cleared by any fetch grant.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            d_grant       - data request accepted this cycle
//            if_grant      - fetch request accepted this cycle
//            if_pending    - fetch request currently valid
//            starve_cnt    - current count, saturates at STARVE_LIMIT
// Config   : only instantiated when MEM_ARB_FAIR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_fair_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = cnt_width(STARVE_LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_grant,
    input  logic             if_grant,
    input  logic             if_pending,
    output logic [CNT_W-1:0] starve_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_grant) begin
            starve_cnt <= '0;
        end else if (d_grant && if_pending &&
                     (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule : mem_arb_fair_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and the
//            load/store unit. One transaction in flight at a time; the
//            response is routed back to the requester that issued it.
//            Data has priority; with MEM_ARB_FAIR_EN defined, fetch is
//            forced through after STARVE_LIMIT data grants while it waits.
// Ports    : clk, rst                    - clock, sync active-high reset
//            if_req_valid/ready, if_addr - fetch request
//            if_rsp_valid/data           - fetch response (1-cycle pulse)
//            d_req_valid/ready, d_addr, d_wdata, d_we, d_whb - data request
//            d_rsp_valid/data            - data response (1-cycle pulse)
//            mem_req_valid/ready, mem_addr, mem_wdata, mem_we, mem_whb
//                                        - memory request
//            mem_rsp_valid/data          - memory response
// Config   : MEM_ARB_FAIR_EN - enables the fetch starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic [2:0]  d_whb,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_whb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int unsigned c_cnt_w = cnt_width(STARVE_LIMIT);

    state_t               r_state;
    owner_t               r_owner;
    logic                 w_idle;
    logic                 w_fair_force;
    logic                 w_grant_d;
    logic                 w_grant_if;
    logic [c_cnt_w-1:0]   w_starve_cnt;

`ifdef MEM_ARB_FAIR_EN
    mem_arb_fair_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fair_ctr (
        .clk        (clk),
        .rst        (rst),
        .d_grant    (w_grant_d),
        .if_grant   (w_grant_if),
        .if_pending (if_req_valid),
        .starve_cnt (w_starve_cnt)
    );
`else
    // No counter: with a constant zero count the override below folds away.
    assign w_starve_cnt = '0;
`endif

    // Fetch overrides data priority once it has been starved long enough.
    assign w_fair_force = if_req_valid &&
                          (w_starve_cnt == c_cnt_w'(STARVE_LIMIT));

    assign w_idle     = (r_state == IDLE);
    assign w_grant_d  = w_idle && d_req_valid && !w_fair_force;
    assign w_grant_if = w_idle && if_req_valid && (!d_req_valid || w_fair_force);

    assign d_req_ready  = w_grant_d;
    assign if_req_ready = w_grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= OWN_IF;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_whb       <= '0;
            if_rsp_valid  <= 1'b0;
            d_rsp_valid   <= 1'b0;
            if_rsp_data   <= '0;
            d_rsp_data    <= '0;
        end else begin
            // Response valids are single-cycle pulses.
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_owner       <= OWN_D;
                        mem_addr      <= d_addr;
                        mem_wdata     <= d_wdata;
                        mem_we        <= d_we;
                        mem_whb       <= d_whb;
                        mem_req_valid <= 1'b1;
                        r_state       <= REQ;
                    end else if (w_grant_if) begin
                        // Fetches are always word reads.
                        r_owner       <= OWN_IF;
                        mem_addr      <= if_addr;
                        mem_wdata     <= '0;
                        mem_we        <= 1'b0;
                        mem_whb       <= WHB_W;
                        mem_req_valid <= 1'b1;
                        r_state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_owner == OWN_D) begin
                            d_rsp_data  <= mem_rsp_data;
                            d_rsp_valid <= 1'b1;
                        end else begin
                            if_rsp_data  <= mem_rsp_data;
                            if_rsp_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//            followed by randomized traffic checked against a transaction-
//            level reference model.
// Config   : MEM_ARB_FAIR_EN - selects the fairness scenario and model rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [2:0]  d_whb;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [2:0]  mem_whb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_we          (d_we),
        .d_whb         (d_whb),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_data    (d_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_whb       (mem_whb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    task automatic clear_inputs();
        if_req_valid = 1'b0; if_addr = '0;
        d_req_valid = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_whb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Called one cycle after the arbiter entered REQ: memory accepts at once
    // and answers on the next cycle. Returns in the response-pulse cycle.
    task automatic finish_txn(input logic [31:0] data);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        total++;
        if ({mem_req_valid, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_valids: got %b want 00000",
                     {mem_req_valid, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready});
        end
        total++;
        if ({mem_addr, mem_wdata, mem_we, mem_whb} !== 68'b0) begin
            bad++;
            $display("FAIL reset_mem_fields: got addr=%h wdata=%h we=%b whb=%0d want all 0",
                     mem_addr, mem_wdata, mem_we, mem_whb);
        end
        total++;
        if ({if_rsp_data, d_rsp_data} !== 64'b0) begin
            bad++;
            $display("FAIL reset_rsp_data: got if=%h d=%h want 0", if_rsp_data, d_rsp_data);
        end
`ifdef MEM_ARB_FAIR_EN
        total++;
        if (dut.u_fair_ctr.starve_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_starve_cnt: got %0d want 0", dut.u_fair_ctr.starve_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_lone_fetch();
        if_addr = 32'h0000_0040;
        if_req_valid = 1'b1;
        #1;
        total++;
        if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lone_accept: got if_rdy=%b d_rdy=%b want 1 0", if_req_ready, d_req_ready);
        end
        step();
        if_req_valid = 1'b0;
        total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_whb !== WHB_W) begin
            bad++;
            $display("FAIL lone_mem_req: got v=%b addr=%h we=%b whb=%0d want 1 00000040 0 2",
                     mem_req_valid, mem_addr, mem_we, mem_whb);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        total++;
        if (mem_req_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL lone_wait: got mem_v=%b if_rsp_v=%b want 0 0", mem_req_valid, if_rsp_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0013;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        total++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h13 || d_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL lone_rsp: got if_v=%b data=%h d_v=%b want 1 00000013 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        step();
        total++;
        if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h13) begin
            bad++;
            $display("FAIL lone_hold: got if_v=%b data=%h want 0 00000013", if_rsp_valid, if_rsp_data);
        end
    endtask

    task automatic test_contention();
        if_addr = 32'h0000_0044; if_req_valid = 1'b1;
        d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_whb = WHB_W;
        d_req_valid = 1'b1;
        #1;
        total++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL contend_grant: got d_rdy=%b if_rdy=%b want 1 0", d_req_ready, if_req_ready);
        end
        step();
        d_req_valid = 1'b0; d_we = 1'b0;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF ||
            mem_we !== 1'b1 || mem_whb !== WHB_W || if_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL contend_store: got v=%b addr=%h wd=%h we=%b whb=%0d if_rdy=%b want 1 00000100 deadbeef 1 2 0",
                     mem_req_valid, mem_addr, mem_wdata, mem_we, mem_whb, if_req_ready);
        end
        finish_txn(32'h5555_AAAA);
        #1;
        total++;
        if (d_rsp_valid !== 1'b1 || if_req_ready !== 1'b1 || if_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL contend_fetch_after: got d_rsp_v=%b if_rdy=%b if_rsp_v=%b want 1 1 0",
                     d_rsp_valid, if_req_ready, if_rsp_valid);
        end
        step();
        if_req_valid = 1'b0;
        total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0 || mem_whb !== WHB_W) begin
            bad++;
            $display("FAIL contend_fetch_req: got v=%b addr=%h we=%b whb=%0d want 1 00000044 0 2",
                     mem_req_valid, mem_addr, mem_we, mem_whb);
        end
        finish_txn(32'h0000_0093);
        total++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h93 || d_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL contend_fetch_rsp: got if_v=%b data=%h d_v=%b want 1 00000093 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        step();
    endtask

    task automatic test_stall();
        d_addr = 32'h0000_0200; d_wdata = 32'h1111_2222; d_we = 1'b0; d_whb = WHB_BU;
        d_req_valid = 1'b1;
        step();
        // Both requesters keep asking and the data inputs change while stalled.
        if_req_valid = 1'b1;
        d_addr = 32'hFFFF_0000; d_wdata = 32'h0; d_we = 1'b1; d_whb = WHB_H;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1111_2222 ||
                mem_we !== 1'b0 || mem_whb !== WHB_BU || if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%b addr=%h wd=%h we=%b whb=%0d rdy=%b%b want 1 00000200 11112222 0 3 00",
                         i, mem_req_valid, mem_addr, mem_wdata, mem_we, mem_whb, if_req_ready, d_req_ready);
            end
            step();
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        finish_txn(32'hCAFE_0001);
        total++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hCAFE_0001 || if_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_rsp: got d_v=%b data=%h if_v=%b want 1 cafe0001 0",
                     d_rsp_valid, d_rsp_data, if_rsp_valid);
        end
        step();
    endtask

    task automatic test_early_rsp();
        if_addr = 32'h0000_0080; if_req_valid = 1'b1;
        step();
        if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
        step();
        mem_rsp_valid = 1'b0;
        total++;
        if (mem_req_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_rsp_ignored: got mem_v=%b if_rsp_v=%b want 1 0", mem_req_valid, if_rsp_valid);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_1234;
        step();
        mem_rsp_valid = 1'b0;
        total++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h1234) begin
            bad++;
            $display("FAIL early_rsp_real: got v=%b data=%h want 1 00001234", if_rsp_valid, if_rsp_data);
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        d_addr = 32'h0000_0300; d_wdata = 32'h0000_7777; d_we = 1'b1; d_whb = WHB_H;
        d_req_valid = 1'b1;
        step();
        d_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_9999;
        step();
        rst = 1'b0;
        mem_rsp_valid = 1'b0;
        total++;
        if ({mem_req_valid, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready} !== 5'b0 ||
            {mem_addr, mem_wdata, mem_we, mem_whb} !== 68'b0 || {if_rsp_data, d_rsp_data} !== 64'b0) begin
            bad++;
            $display("FAIL rst_wait_clear: got v=%b addr=%h wd=%h we=%b whb=%0d ifd=%h dd=%h want all 0",
                     {mem_req_valid, if_rsp_valid, d_rsp_valid, if_req_ready, d_req_ready},
                     mem_addr, mem_wdata, mem_we, mem_whb, if_rsp_data, d_rsp_data);
        end
        step();
        total++;
        if (d_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_quiet: got d_rsp_v=%b mem_v=%b want 0 0", d_rsp_valid, mem_req_valid);
        end
    endtask

    // Both requesters valid continuously, memory always ready/answering:
    // each IDLE cycle comes every third cycle.
`ifdef MEM_ARB_FAIR_EN
    task automatic test_fairness();
        do_reset();
        if_addr = 32'h0000_0500; if_req_valid = 1'b1;
        d_addr = 32'h0000_0600; d_we = 1'b0; d_whb = WHB_W; d_req_valid = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0042;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (d_req_ready !== (k < 4) || if_req_ready !== (k == 4)) begin
                bad++;
                $display("FAIL fair_grant[%0d]: got d_rdy=%b if_rdy=%b want %b %b",
                         k, d_req_ready, if_req_ready, (k < 4), (k == 4));
            end
            step();
            total++;
            if (dut.u_fair_ctr.starve_cnt !== ((k < 4) ? 3'(k + 1) : 3'd0)) begin
                bad++;
                $display("FAIL fair_cnt[%0d]: got %0d want %0d",
                         k, dut.u_fair_ctr.starve_cnt, (k < 4) ? k + 1 : 0);
            end
            step();
            step();
        end
        clear_inputs();
        step();
    endtask
`else
    task automatic test_strict_priority();
        do_reset();
        if_addr = 32'h0000_0500; if_req_valid = 1'b1;
        d_addr = 32'h0000_0600; d_we = 1'b0; d_whb = WHB_W; d_req_valid = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0042;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++;
            if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL strict_grant[%0d]: got d_rdy=%b if_rdy=%b want 1 0", k, d_req_ready, if_req_ready);
            end
            step();
            step();
            step();
        end
        clear_inputs();
        step();
    endtask
`endif

    // Randomized traffic against a transaction-level model: at most one
    // transaction outstanding; it is granted by priority when none is open,
    // issued to memory, and completed by the first response after memory
    // took it. Reset is injected occasionally.
    task automatic test_random();
        bit          pend, macc, own_d, fair, frc, gi, gd, wd_chk;
        bit          e_mreq, e_irv, e_drv, e_we;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
        logic [2:0]  e_whb;
        int          cnt;
`ifdef MEM_ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        do_reset();
        pend = 0; macc = 0; own_d = 0; wd_chk = 1;
        e_mreq = 0; e_irv = 0; e_drv = 0; e_we = 0;
        e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0; e_whb = '0;
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            total++;
            if ({mem_req_valid, if_rsp_valid, d_rsp_valid} !== {e_mreq, e_irv, e_drv}) begin
                bad++;
                $display("FAIL rnd_valids@%0d: got mem/if/d=%b want %b",
                         c, {mem_req_valid, if_rsp_valid, d_rsp_valid}, {e_mreq, e_irv, e_drv});
            end
            total++;
            if ({mem_addr, mem_we, mem_whb} !== {e_addr, e_we, e_whb} ||
                (wd_chk && mem_wdata !== e_wdata)) begin
                bad++;
                $display("FAIL rnd_mem_fields@%0d: got addr=%h wd=%h we=%b whb=%0d want %h %h %b %0d",
                         c, mem_addr, mem_wdata, mem_we, mem_whb, e_addr, e_wdata, e_we, e_whb);
            end
            total++;
            if (if_rsp_data !== e_ird || d_rsp_data !== e_drd) begin
                bad++;
                $display("FAIL rnd_rsp_data@%0d: got if=%h d=%h want %h %h", c, if_rsp_data, d_rsp_data, e_ird, e_drd);
            end
`ifdef MEM_ARB_FAIR_EN
            total++;
            if (dut.u_fair_ctr.starve_cnt !== 3'(cnt)) begin
                bad++;
                $display("FAIL rnd_starve_cnt@%0d: got %0d want %0d", c, dut.u_fair_ctr.starve_cnt, cnt);
            end
`endif
            rst           = ($urandom_range(0, 199) == 0);
            if_req_valid  = ($urandom_range(0, 3) != 0);
            d_req_valid   = ($urandom_range(0, 3) != 0);
            if_addr       = $urandom;
            d_addr        = $urandom;
            d_wdata       = $urandom;
            d_we          = 1'($urandom_range(0, 1));
            d_whb         = 3'($urandom_range(0, 4));
            mem_req_ready = ($urandom_range(0, 2) != 0);
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_data  = $urandom;
            #1;
            gi = 0; gd = 0;
            if (!pend) begin
                frc = fair && if_req_valid && (cnt == int'(LIMIT));
                gd  = d_req_valid && !frc;
                gi  = if_req_valid && !gd;
            end
            total++;
            if (if_req_ready !== gi || d_req_ready !== gd) begin
                bad++;
                $display("FAIL rnd_ready@%0d: got if=%b d=%b want %b %b", c, if_req_ready, d_req_ready, gi, gd);
            end
            e_irv = 0; e_drv = 0;
            if (rst) begin
                pend = 0; macc = 0; e_mreq = 0; wd_chk = 1;
                e_addr = '0; e_wdata = '0; e_we = 0; e_whb = '0; e_ird = '0; e_drd = '0;
                cnt = 0;
            end else if (!pend) begin
                if (gd || gi) begin
                    pend = 1; macc = 0; own_d = gd; e_mreq = 1;
                    e_addr = gd ? d_addr : if_addr;
                    e_wdata = d_wdata;
                    wd_chk = gd;
                    e_we = gd ? d_we : 1'b0;
                    e_whb = gd ? d_whb : WHB_W;
                end
                if (fair) begin
                    if (gi) cnt = 0;
                    else if (gd && if_req_valid && cnt < int'(LIMIT)) cnt++;
                end
            end else if (!macc) begin
                if (mem_req_ready) begin
                    macc = 1; e_mreq = 0;
                end
            end else if (mem_rsp_valid) begin
                pend = 0;
                if (own_d) begin
                    e_drv = 1; e_drd = mem_rsp_data;
                end else begin
                    e_irv = 1; e_ird = mem_rsp_data;
                end
            end
            step();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_stall();
        test_early_rsp();
        test_reset_in_wait();
`ifdef MEM_ARB_FAIR_EN
        test_fairness();
`else
        test_strict_priority();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
